// File: rtl/wb_ram_bist.sv
// Wishbone B3 classic initiator running a write-then-readback self-test on a 32-bit memory slave.
// Optional mismatch counter (err_cnt_o, full read pass) enabled by defining WB_RAM_BIST_ERR_CNT_EN.
module wb_ram_bist #(
    parameter int DEPTH   = 512,
    parameter int AW      = 11,
    parameter int TIMEOUT = 16
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          start_i,
    input  logic [31:0]   seed_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          pass_o,
    output logic          timeout_o,
    output logic [AW-1:0] fail_addr_o,
    output logic [31:0]   fail_data_o,
    output logic [31:0]   adr_o,
    output logic [31:0]   dat_o,
    input  logic [31:0]   dat_i,
    output logic [3:0]    sel_o,
    output logic          cyc_o,
    output logic          stb_o,
    output logic          we_o,
    input  logic          ack_i,
`ifdef WB_RAM_BIST_ERR_CNT_EN
    input  logic          err_i,
    output logic [15:0]   err_cnt_o
`else
    input  logic          err_i
`endif
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [31:0] STEP = 32'h0101_0101;

    typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, GAP, DONE} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [31:0]   pat;
    logic [31:0]   seed_q;
    logic          rd_pass;
    logic [TW-1:0] tcnt;
    logic [31:0]   cur_addr;
    logic          rd_bad;
    logic          stop_rd;
    logic          any_bad;

    // Byte address of the current word, truncated to AW bits.
    always_comb begin
        cur_addr = 32'(idx) << 2;
        if (AW < 32) cur_addr = cur_addr & ((32'd1 << AW) - 32'd1);
    end

    assign rd_bad = rd_pass && (dat_i != pat);

`ifdef WB_RAM_BIST_ERR_CNT_EN
    logic mism;
    assign stop_rd = rd_pass && (idx == LAST);
    assign any_bad = mism || rd_bad;
`else
    assign stop_rd = rd_bad || (rd_pass && (idx == LAST));
    assign any_bad = rd_bad;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            idx         <= '0;
            pat         <= '0;
            seed_q      <= '0;
            rd_pass     <= 1'b0;
            tcnt        <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            timeout_o   <= 1'b0;
            fail_addr_o <= '0;
            fail_data_o <= '0;
            adr_o       <= '0;
            dat_o       <= '0;
            sel_o       <= '0;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
`ifdef WB_RAM_BIST_ERR_CNT_EN
            mism        <= 1'b0;
            err_cnt_o   <= '0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: if (start_i) begin
                    state       <= WR_REQ;
                    seed_q      <= seed_i;
                    pat         <= seed_i;
                    idx         <= '0;
                    rd_pass     <= 1'b0;
                    tcnt        <= '0;
                    busy_o      <= 1'b1;
                    pass_o      <= 1'b0;
                    timeout_o   <= 1'b0;
                    fail_addr_o <= '0;
                    fail_data_o <= '0;
                    adr_o       <= '0;
                    dat_o       <= seed_i;
                    sel_o       <= 4'hF;
                    cyc_o       <= 1'b1;
                    stb_o       <= 1'b1;
                    we_o        <= 1'b1;
`ifdef WB_RAM_BIST_ERR_CNT_EN
                    mism        <= 1'b0;
                    err_cnt_o   <= '0;
`endif
                end
                WR_REQ, RD_REQ: begin
                    // err_i wins over a simultaneous ack_i; both abort like a timeout.
                    if (err_i || (!ack_i && tcnt == TLAST)) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                        cyc_o  <= 1'b0;
                        stb_o  <= 1'b0;
                        we_o   <= 1'b0;
                        sel_o  <= '0;
                        if (err_i) begin
                            fail_addr_o <= cur_addr[AW-1:0];
                            fail_data_o <= '0;
                        end else begin
                            timeout_o <= 1'b1;
                        end
                    end else if (ack_i) begin
                        cyc_o <= 1'b0;
                        stb_o <= 1'b0;
                        we_o  <= 1'b0;
                        sel_o <= '0;
`ifdef WB_RAM_BIST_ERR_CNT_EN
                        if (rd_bad) begin
                            mism <= 1'b1;
                            if (!mism) begin
                                fail_addr_o <= cur_addr[AW-1:0];
                                fail_data_o <= dat_i;
                            end
                            if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
                        end
`else
                        if (rd_bad) begin
                            fail_addr_o <= cur_addr[AW-1:0];
                            fail_data_o <= dat_i;
                        end
`endif
                        if (stop_rd) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                            pass_o <= !any_bad;
                        end else begin
                            state <= GAP;
                            if (idx == LAST) begin
                                idx     <= '0;
                                pat     <= seed_q;
                                rd_pass <= 1'b1;
                            end else begin
                                idx <= idx + 1'b1;
                                pat <= pat + STEP;
                            end
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                GAP: begin
                    state <= rd_pass ? RD_REQ : WR_REQ;
                    tcnt  <= '0;
                    adr_o <= cur_addr;
                    dat_o <= rd_pass ? 32'd0 : pat;
                    sel_o <= 4'hF;
                    cyc_o <= 1'b1;
                    stb_o <= 1'b1;
                    we_o  <= !rd_pass;
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_ram_bist.sv
// Directed bench for wb_ram_bist: behavioural Wishbone RAM with wait-state, err, stuck-bit and
// corruption injection; mismatch-counter checks are compiled when WB_RAM_BIST_ERR_CNT_EN is defined.
module tb_wb_ram_bist;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] seed_i = '0;
    logic        busy_o, done_o, pass_o, timeout_o;
    logic [10:0] fail_addr_o;
    logic [31:0] fail_data_o, adr_o, dat_o;
    logic [31:0] dat_i = '0;
    logic [3:0]  sel_o;
    logic        cyc_o, stb_o, we_o;
    logic        ack_i = 1'b0;
    logic        err_i = 1'b0;
`ifdef WB_RAM_BIST_ERR_CNT_EN
    logic [15:0] err_cnt_o;
`endif

    int checks = 0;
    int fails = 0;

    // slave configuration, written only by the stimulus process
    bit          never_ack = 1'b0;
    bit          rnd_wait = 1'b0;
    int          err_word = -1;
    int          stuck_word = -1;
    bit [511:0]  corrupt = '0;

    logic [31:0] mem [0:511];
    int          wcnt = 0;
    int          cur_wait = 0;
    int          wr0_cnt = 0;

    always #5 clk_i = ~clk_i;

    wb_ram_bist dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .seed_i(seed_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
        .fail_addr_o(fail_addr_o), .fail_data_o(fail_data_o),
        .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .sel_o(sel_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .ack_i(ack_i),
`ifdef WB_RAM_BIST_ERR_CNT_EN
        .err_i(err_i), .err_cnt_o(err_cnt_o)
`else
        .err_i(err_i)
`endif
    );

    // Registered-ack RAM: ack one cycle after stb plus cur_wait extra cycles.
    always @(posedge clk_i) begin
        int w;
        logic [31:0] d;
        ack_i <= 1'b0;
        err_i <= 1'b0;
        if (cyc_o && stb_o && !ack_i && !err_i) begin
            if (!never_ack) begin
                if (wcnt >= cur_wait) begin
                    wcnt <= 0;
                    cur_wait <= rnd_wait ? int'($urandom_range(0, 3)) : 0;
                    w = int'(adr_o[10:2]);
                    if (we_o && w == err_word) begin
                        err_i <= 1'b1;
                    end else begin
                        ack_i <= 1'b1;
                        if (we_o) begin
                            mem[w] <= dat_o;
                            if (w == 0) wr0_cnt <= wr0_cnt + 1;
                        end else begin
                            d = mem[w];
                            if (w == stuck_word) d[5] = 1'b1;
                            if (corrupt[w]) d = d ^ 32'h1;
                            dat_i <= d;
                        end
                    end
                end else begin
                    wcnt <= wcnt + 1;
                end
            end
        end else begin
            wcnt <= 0;
        end
    end

    task automatic pulse_start(input logic [31:0] s);
        @(negedge clk_i);
        seed_i = s;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // Returns edges since the start edge until done_o is seen (done in period n -> n+1).
    task automatic wait_done(input int limit, output int edges, output bit ok);
        edges = 1;
        ok = 1'b0;
        while (edges <= limit) begin
            if (done_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_i);
            edges++;
        end
    endtask

    task automatic test_reset;
        rst_n_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++; if ({busy_o, done_o, pass_o, timeout_o} !== 4'b0) begin fails++; $display("FAIL reset_status: got %b expected 0000", {busy_o, done_o, pass_o, timeout_o}); end
        checks++; if ({cyc_o, stb_o, we_o, sel_o} !== 7'b0) begin fails++; $display("FAIL reset_bus: got %b expected 0", {cyc_o, stb_o, we_o, sel_o}); end
        checks++; if ({adr_o, dat_o, fail_addr_o, fail_data_o} !== '0) begin fails++; $display("FAIL reset_data: adr %h dat %h fa %h fd %h expected 0", adr_o, dat_o, fail_addr_o, fail_data_o); end
        rst_n_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_zero_wait;
        int e; bit ok;
        pulse_start(32'h0000_0000);
        checks++; if ({busy_o, cyc_o, stb_o, we_o, sel_o} !== 8'b1111_1111) begin fails++; $display("FAIL first_write_ctl: got %b expected 11111111", {busy_o, cyc_o, stb_o, we_o, sel_o}); end
        checks++; if (adr_o !== 32'h0 || dat_o !== 32'h0) begin fails++; $display("FAIL first_write_data: adr %h dat %h expected 0 0", adr_o, dat_o); end
        wait_done(4000, e, ok);
        checks++; if (!ok || e != 3072) begin fails++; $display("FAIL zero_wait_latency: got %0d edges (done %0b) expected 3072", e, ok); end
        checks++; if (pass_o !== 1'b1 || timeout_o !== 1'b0) begin fails++; $display("FAIL zero_wait_result: pass %b timeout %b expected 1 0", pass_o, timeout_o); end
        checks++; if (mem[3] !== 32'h0303_0303) begin fails++; $display("FAIL word3: got %h expected 03030303", mem[3]); end
        checks++; if (mem[511] !== 32'h0101_00FF) begin fails++; $display("FAIL word511: got %h expected 010100ff", mem[511]); end
        @(negedge clk_i);
        checks++; if (done_o !== 1'b0 || busy_o !== 1'b0 || pass_o !== 1'b1) begin fails++; $display("FAIL done_pulse: done %b busy %b pass %b expected 0 0 1", done_o, busy_o, pass_o); end
    endtask

    task automatic test_stuck_bit;
        int e; bit ok;
        stuck_word = 16;
        pulse_start(32'hA5A5_0000);
        wait_done(4000, e, ok);
        checks++; if (!ok || pass_o !== 1'b0 || timeout_o !== 1'b0) begin fails++; $display("FAIL stuck_result: done %b pass %b timeout %b expected 1 0 0", ok, pass_o, timeout_o); end
        checks++; if (fail_addr_o !== 11'h040) begin fails++; $display("FAIL stuck_addr: got %h expected 040", fail_addr_o); end
        checks++; if (fail_data_o !== 32'hB5B5_1030) begin fails++; $display("FAIL stuck_data: got %h expected b5b51030", fail_data_o); end
        stuck_word = -1;
        @(negedge clk_i);
    endtask

    task automatic test_timeout;
        int nstb = 0, ndone = 0;
        never_ack = 1'b1;
        pulse_start(32'h1111_1111);
        for (int i = 0; i < 40; i++) begin
            if (stb_o) nstb++;
            if (done_o) ndone++;
            @(negedge clk_i);
        end
        checks++; if (nstb != 16) begin fails++; $display("FAIL timeout_stb_len: got %0d expected 16", nstb); end
        checks++; if (ndone != 1) begin fails++; $display("FAIL timeout_done_count: got %0d expected 1", ndone); end
        checks++; if (timeout_o !== 1'b1 || pass_o !== 1'b0 || fail_addr_o !== 11'h0) begin fails++; $display("FAIL timeout_result: to %b pass %b fa %h expected 1 0 000", timeout_o, pass_o, fail_addr_o); end
        never_ack = 1'b0;
    endtask

    task automatic test_err;
        int e, ncyc = 0; bit ok;
        err_word = 7;
        pulse_start(32'hDEAD_BEEF);
        wait_done(4000, e, ok);
        checks++; if (!ok || pass_o !== 1'b0 || timeout_o !== 1'b0) begin fails++; $display("FAIL err_result: done %b pass %b timeout %b expected 1 0 0", ok, pass_o, timeout_o); end
        checks++; if (fail_addr_o !== 11'h01C || fail_data_o !== 32'h0) begin fails++; $display("FAIL err_addr: fa %h fd %h expected 01c 0", fail_addr_o, fail_data_o); end
        for (int i = 0; i < 20; i++) begin
            if (cyc_o || stb_o) ncyc++;
            @(negedge clk_i);
        end
        checks++; if (ncyc != 0) begin fails++; $display("FAIL err_quiet_bus: got %0d busy cycles expected 0", ncyc); end
        err_word = -1;
    endtask

    task automatic test_multi_corrupt;
        int e; bit ok;
        corrupt[1] = 1'b1; corrupt[64] = 1'b1; corrupt[511] = 1'b1;
        pulse_start(32'h1234_5678);
        wait_done(4000, e, ok);
`ifdef WB_RAM_BIST_ERR_CNT_EN
        checks++; if (!ok || e != 3072) begin fails++; $display("FAIL cnt_full_pass: got %0d edges expected 3072", e); end
        checks++; if (err_cnt_o !== 16'd3) begin fails++; $display("FAIL cnt_value: got %0d expected 3", err_cnt_o); end
`else
        checks++; if (!ok || e != 1542) begin fails++; $display("FAIL early_stop: got %0d edges expected 1542", e); end
`endif
        checks++; if (pass_o !== 1'b0 || fail_addr_o !== 11'h004) begin fails++; $display("FAIL multi_addr: pass %b fa %h expected 0 004", pass_o, fail_addr_o); end
        checks++; if (fail_data_o !== 32'h1335_5778) begin fails++; $display("FAIL multi_data: got %h expected 13355778", fail_data_o); end
        corrupt = '0;
        @(negedge clk_i);
    endtask

    task automatic test_restart_and_reset;
        int e, w0, n = 0; bit ok;
        rnd_wait = 1'b1;
        w0 = wr0_cnt;
        pulse_start(32'hCAFE_0001);
        repeat (60) @(negedge clk_i);
        pulse_start(32'h0BAD_0BAD);
        checks++; if (busy_o !== 1'b1) begin fails++; $display("FAIL restart_busy: got %b expected 1", busy_o); end
        while (!(stb_o && !we_o) && n < 20000) begin @(negedge clk_i); n++; end
        checks++; if (n >= 20000) begin fails++; $display("FAIL reach_read_pass: no read within %0d cycles", n); end
        repeat (5) @(negedge clk_i);
        checks++; if (wr0_cnt - w0 != 1) begin fails++; $display("FAIL restart_ignored: word0 written %0d times expected 1", wr0_cnt - w0); end
        #2 rst_n_i = 1'b0;
        #1;
        checks++; if ({busy_o, done_o, pass_o, timeout_o, cyc_o, stb_o, we_o, sel_o} !== 11'b0 || adr_o !== 32'h0) begin fails++; $display("FAIL async_reset: ctl %b adr %h expected 0 0", {busy_o, done_o, pass_o, timeout_o, cyc_o, stb_o, we_o, sel_o}, adr_o); end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        pulse_start(32'h5555_AAAA);
        wait_done(20000, e, ok);
        checks++; if (!ok || pass_o !== 1'b1 || timeout_o !== 1'b0) begin fails++; $display("FAIL post_reset_pass: done %b pass %b timeout %b expected 1 1 0", ok, pass_o, timeout_o); end
        rnd_wait = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stuck_bit();
        test_timeout();
        test_err();
        test_multi_corrupt();
        test_restart_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
